// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_mem_arb_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned OP_W         = 4;
  localparam int unsigned NUM_PORTS    = 2;
  // Data memory spans 2**ADDR_LIMIT_W bytes; any higher address bit set is an error.
  localparam int unsigned ADDR_LIMIT_W = 10;

  // Memory op encoding: {read, type[2:0]}
  localparam logic [OP_W-1:0] OP_IDLE = 4'b0000;
  localparam logic [OP_W-1:0] OP_LB   = 4'b1000;
  localparam logic [OP_W-1:0] OP_LBU  = 4'b1001;
  localparam logic [OP_W-1:0] OP_LH   = 4'b1010;
  localparam logic [OP_W-1:0] OP_LHU  = 4'b1011;
  localparam logic [OP_W-1:0] OP_LW   = 4'b1100;
  localparam logic [OP_W-1:0] OP_SB   = 4'b0101;
  localparam logic [OP_W-1:0] OP_SH   = 4'b0110;
  localparam logic [OP_W-1:0] OP_SW   = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  // Request captured at accept time; the requester may drop its inputs afterwards.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [OP_W-1:0]   op;
    logic              port;
    logic              err;
  } arb_req_t;

  function automatic logic op_is_load(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LW) || (op == OP_SB)  || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_is_half(input logic [OP_W-1:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic op_is_word(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_mem_req_check.sv
// Combinational legality check for one memory request (op, range, alignment).
module mem_req_check
  import data_mem_arb_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] addr,
  output logic              err_c
);

  logic illegal_op;
  logic out_of_range;
  logic half_misaligned;
  logic word_misaligned;

  // Any one of the four conditions rejects the request.
  always_comb begin
    illegal_op      = !op_is_legal(op);
    out_of_range    = |addr[ADDR_W-1:ADDR_LIMIT_W];
    half_misaligned = op_is_half(op) && addr[0];
    word_misaligned = op_is_word(op) && (|addr[1:0]);
    err_c           = illegal_op || out_of_range || half_misaligned || word_misaligned;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single combinational-read data memory.
// One transaction at a time: accept (IDLE) -> memory access (ACCESS) -> response (RESP).
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                req_valid,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    req_wdata,
  input  logic [NUM_PORTS-1:0][OP_W-1:0]      req_op,
  output logic [NUM_PORTS-1:0]                req_ready,
  output logic [NUM_PORTS-1:0]                rsp_valid,
  output logic [DATA_W-1:0]                   rsp_rdata,
  output logic                                rsp_err,
  output logic [ADDR_W-1:0]                   mem_address,
  output logic [DATA_W-1:0]                   mem_wdata,
  output logic [OP_W-1:0]                     mem_op,
  input  logic [DATA_W-1:0]                   mem_rdata
);

  arb_state_t          state_q;
  arb_state_t          state_d;
  arb_req_t            req_q;
  arb_req_t            win_req_c;
  logic                last_grant_q;
  logic [NUM_PORTS-1:0] grant_c;
  logic                win_port_c;
  logic                accept_c;
  logic                check_err_c;
  logic [DATA_W-1:0]   load_data_c;

  // Pick a winner among valid ports: fixed priority or alternate on ties.
  always_comb begin
    grant_c = '0;
    if (PRIO_MODE != 0) begin
      if (req_valid[0])      grant_c = 2'b01;
      else if (req_valid[1]) grant_c = 2'b10;
    end else begin
      case (req_valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = last_grant_q ? 2'b01 : 2'b10;
        default: grant_c = '0;
      endcase
    end
    win_port_c = grant_c[1];
  end

  // Winner's request, muxed once so a single checker serves both ports.
  mem_req_check u_check (
    .op    (req_op[win_port_c]),
    .addr  (req_addr[win_port_c]),
    .err_c (check_err_c)
  );

  // Assemble the request image that gets latched on accept.
  always_comb begin
    win_req_c.addr  = req_addr[win_port_c];
    win_req_c.wdata = req_wdata[win_port_c];
    win_req_c.op    = req_op[win_port_c];
    win_req_c.port  = win_port_c;
    win_req_c.err   = check_err_c;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake; ready is held low while reset is asserted.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|grant_c) && !rst) begin
          req_ready = grant_c;
          accept_c  = 1'b1;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Loads return memory data; stores and rejected requests return zero.
  always_comb begin
    load_data_c = '0;
    if (!req_q.err && op_is_load(req_q.op)) load_data_c = mem_rdata;
  end

  // Request latch, memory strobe, response strobe and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q        <= '0;
      mem_op       <= OP_IDLE;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (accept_c) begin
        req_q        <= win_req_c;
        mem_op       <= check_err_c ? OP_IDLE : win_req_c.op;
        last_grant_q <= win_port_c;
      end
      if (state_q == ST_ACCESS) begin
        mem_op    <= OP_IDLE;
        rsp_valid <= req_q.port ? 2'b10 : 2'b01;
        rsp_err   <= req_q.err;
        rsp_rdata <= load_data_c;
      end
    end
  end

  // Address and store data stay parked on the latched values between accesses.
  assign mem_address = req_q.addr;
  assign mem_wdata   = req_q.wdata;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  per-port request valid; bit i is port i (0 = CPU LSU, 1 = debug loader).
REQ-005 req_addr  input  2x32  per-port byte address.
REQ-006 req_wdata  input  2x32  per-port store data; low bytes used for sb/sh.
REQ-007 req_op  input  2x4  per-port op: {read, type[2:0]}; 1000 lb, 1001 lbu, 1010 lh, 1011 lhu, 1100 lw, 0101 sb, 0110 sh, 0111 sw.
REQ-008 req_ready  output  2  one-hot accept; a request transfers on valid&ready.
REQ-009 rsp_valid  output  2  one-hot, one-cycle response strobe to the owning port.
REQ-010 rsp_rdata  output  32  load result, qualified by rsp_valid; 0 for stores and errors.
REQ-011 rsp_err  output  1  error flag, qualified by rsp_valid.
REQ-012 mem_address  output  32  to data memory address.
REQ-013 mem_wdata  output  32  to data memory D_in.
REQ-014 mem_op  output  4  to data memory read_write_en; 0000 = idle.
REQ-015 mem_rdata  input  32  from data memory D_out (combinational read).

Function
REQ-016 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS on any accept; ACCESS->RESP always; RESP->IDLE always.
REQ-017 req_ready SHALL be nonzero only in IDLE, and only for the arbitration winner among asserted req_valid.
REQ-018 Round-robin: with both valid, grant the port not granted last; last_grant updates on every accept.
REQ-019 Fixed priority: port 0 wins whenever valid.
REQ-020 On accept, latch addr, wdata, op, port id, and the error decision into registers; inputs need not stay stable afterward.
REQ-021 Error if op is not in the REQ-007 list, addr[31:10] != 0, halfword op with addr[0] = 1, or word op with addr[1:0] != 0.
REQ-022 In ACCESS, drive latched address, wdata, op onto mem_*; for errored requests mem_op SHALL stay 0000.
REQ-023 Outside ACCESS, mem_op = 0000; mem_address and mem_wdata hold their latched values.
REQ-024 Load data SHALL be sampled from mem_rdata at the end of ACCESS; stores commit at the same edge.
REQ-025 Latency: accept at edge N, mem access in cycle N+1, rsp_valid high in cycle N+2 for exactly one cycle.
REQ-026 Peak throughput is one request per 3 cycles; a new accept is possible in the IDLE cycle right after RESP.
REQ-027 A port holding req_valid SHALL be granted within 3 transactions in round-robin mode (no starvation).
REQ-028 rsp_err = 1 SHALL force rsp_rdata = 0.

Reset
REQ-029 On rst: state = IDLE; req_ready, rsp_valid, rsp_rdata, rsp_err, mem_op, mem_address, mem_wdata = 0; last_grant = 1, so port 0 wins the first tie.
REQ-030 Reset during ACCESS or RESP SHALL abort the transaction with no response; a store whose commit edge has already occurred stays committed.

Structure
REQ-031 Package data_mem_arb_pkg SHALL hold the op encoding constants, the state enum, and the address-limit constant (10 bits).
REQ-032 One combinational sub-module, mem_req_check, SHALL implement the REQ-021 error decision; it is instantiated once, on the arbitration winner.

Verification
REQ-033 Port 0 sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> accept-to-rsp 2 cycles, rdata 0xDEADBEEF, err 0.
REQ-034 Both ports valid continuously after reset -> grants alternate 0,1,0,1; each rsp_valid goes to the accepted port.
REQ-035 lh addr 0x13 -> mem_op stays 0000 throughout, rsp_err 1, rdata 0; memory unchanged.
REQ-036 sb 0x85 to addr 0x21, then lb 0x21 -> rdata 0xFFFFFF85; lbu 0x21 -> 0x00000085.
REQ-037 Load with addr 0x400 -> rsp_err 1; PRIO_MODE = 1 with both valid -> port 0 granted every time.
REQ-038 rst asserted mid-ACCESS of a load -> all outputs 0 immediately, no rsp_valid, next accept goes to port 0 on a tie.
